spatz_vrf_wb_arbiter: RTL and testbench

SPATZ_VRF_WB_ARBITER -- requirements
Module: spatz_vrf_wb_arbiter

---
 rtl/spatz_vrf_wb_arbiter.sv | 164 ++++++++++++++++
 tb/tb_spatz_vrf_wb_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spatz_vrf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// spatz_vrf_wb_arbiter
//
// Collects write-back requests from the vector units (0 = VFU, 1 = VLSU,
// 2 = VSLD) and steers them onto the banks of the vector register file.
// Every requester owns a one-entry holding buffer; each cycle, every bank
// grants at most one buffered entry, and the granted entry appears on that
// bank's registered write port one edge later.
//
// Per bank the lowest-index buffered requester wins, except that a requester
// that has waited StarveThresh cycles (age saturated) takes precedence over
// non-starved ones; among starved candidates the lowest index still wins.
//
// Handshake: a requester write transfers at a rising edge where both
// req_valid_i[r] and req_ready_o[r] are high. req_ready_o[r] depends only on
// the buffer state and this cycle's grant (never on req_valid_i), and a
// requester may hold or drop its request freely while ready is low.
//
// Ports
//   clk_i, rst_i     clock, synchronous active-high reset
//   req_valid_i      per requester: write request present
//   req_ready_o      per requester: buffer empty or being granted this cycle
//   req_addr_i       per requester write address (bank = addr[BankLsb +: log2 NrBanks])
//   req_data_i       per requester write data
//   req_be_i         per requester byte enables
//   bank_we_o        per bank registered write enable (one cycle per grant)
//   bank_addr_o      per bank address of the granted write (held when idle)
//   bank_data_o      per bank data of the granted write (held when idle)
//   bank_be_o        per bank byte enables of the granted write (held when idle)
//   bank_src_o       per bank index of the granted requester (held when idle)
//   idle_o           no buffered request and no bank write in flight
// -----------------------------------------------------------------------------
module spatz_vrf_wb_arbiter #(
    parameter int unsigned NrBanks      = 4,
    parameter int unsigned NrReq        = 3,
    parameter int unsigned AddrWidth    = 8,
    parameter int unsigned DataWidth    = 64,
    parameter int unsigned BankLsb      = 0,
    parameter int unsigned StarveThresh = 8,
    localparam int unsigned BeWidth     = DataWidth / 8,
    localparam int unsigned BankBits    = $clog2(NrBanks),
    localparam int unsigned SrcWidth    = (NrReq > 1) ? $clog2(NrReq) : 1,
    localparam int unsigned AgeWidth    = $clog2(StarveThresh + 1)
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NrReq-1:0]                    req_valid_i,
    output logic [NrReq-1:0]                    req_ready_o,
    input  logic [NrReq-1:0][AddrWidth-1:0]     req_addr_i,
    input  logic [NrReq-1:0][DataWidth-1:0]     req_data_i,
    input  logic [NrReq-1:0][BeWidth-1:0]       req_be_i,
    output logic [NrBanks-1:0]                  bank_we_o,
    output logic [NrBanks-1:0][AddrWidth-1:0]   bank_addr_o,
    output logic [NrBanks-1:0][DataWidth-1:0]   bank_data_o,
    output logic [NrBanks-1:0][BeWidth-1:0]     bank_be_o,
    output logic [NrBanks-1:0][SrcWidth-1:0]    bank_src_o,
    output logic                                idle_o
);

    // Holding buffers and age counters
    logic [NrReq-1:0]                buf_valid;
    logic [NrReq-1:0][AddrWidth-1:0] buf_addr;
    logic [NrReq-1:0][DataWidth-1:0] buf_data;
    logic [NrReq-1:0][BeWidth-1:0]   buf_be;
    logic [NrReq-1:0][AgeWidth-1:0]  age;

    logic [NrReq-1:0]                starving;
    logic [NrReq-1:0]                grant;

    // Per-bank arbitration results
    logic [NrBanks-1:0]               bank_gnt;
    logic [NrBanks-1:0][SrcWidth-1:0] bank_sel;
    logic [NrBanks-1:0]               any_cand;
    logic [NrBanks-1:0]               old_cand;
    logic [NrBanks-1:0][SrcWidth-1:0] any_sel;
    logic [NrBanks-1:0][SrcWidth-1:0] old_sel;

    always_comb begin
        for (int r = 0; r < NrReq; r++) begin
            starving[r] = (age[r] == AgeWidth'(StarveThresh));
        end
    end

    // Scanning from the highest index down lets the lowest-index candidate
    // overwrite the selection last, so it wins.
    always_comb begin
        any_cand = '0;
        old_cand = '0;
        any_sel  = '0;
        old_sel  = '0;
        bank_gnt = '0;
        bank_sel = '0;
        grant    = '0;
        for (int b = 0; b < NrBanks; b++) begin
            for (int r = int'(NrReq) - 1; r >= 0; r--) begin
                if (buf_valid[r] && (buf_addr[r][BankLsb +: BankBits] == BankBits'(b))) begin
                    any_cand[b] = 1'b1;
                    any_sel[b]  = SrcWidth'(r);
                    if (starving[r]) begin
                        old_cand[b] = 1'b1;
                        old_sel[b]  = SrcWidth'(r);
                    end
                end
            end
            bank_gnt[b] = any_cand[b];
            bank_sel[b] = old_cand[b] ? old_sel[b] : any_sel[b];
            for (int r = 0; r < NrReq; r++) begin
                if (bank_gnt[b] && (bank_sel[b] == SrcWidth'(r))) begin
                    grant[r] = 1'b1;
                end
            end
        end
    end

    // Ready is forced high during reset; the reset branch below ignores any
    // accept in that cycle.
    always_comb begin
        req_ready_o = rst_i ? '1 : (~buf_valid | grant);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            buf_valid   <= '0;
            buf_addr    <= '0;
            buf_data    <= '0;
            buf_be      <= '0;
            age         <= '0;
            bank_we_o   <= '0;
            bank_addr_o <= '0;
            bank_data_o <= '0;
            bank_be_o   <= '0;
            bank_src_o  <= '0;
        end else begin
            for (int r = 0; r < NrReq; r++) begin
                // An accept in the same cycle as a grant replaces the entry.
                if (req_valid_i[r] && req_ready_o[r]) begin
                    buf_valid[r] <= 1'b1;
                    buf_addr[r]  <= req_addr_i[r];
                    buf_data[r]  <= req_data_i[r];
                    buf_be[r]    <= req_be_i[r];
                end else if (grant[r]) begin
                    buf_valid[r] <= 1'b0;
                end
                if (grant[r] || !buf_valid[r]) begin
                    age[r] <= '0;
                end else if (!starving[r]) begin
                    age[r] <= age[r] + AgeWidth'(1);
                end
            end
            for (int b = 0; b < NrBanks; b++) begin
                bank_we_o[b] <= bank_gnt[b];
                if (bank_gnt[b]) begin
                    bank_addr_o[b] <= buf_addr[bank_sel[b]];
                    bank_data_o[b] <= buf_data[bank_sel[b]];
                    bank_be_o[b]   <= buf_be[bank_sel[b]];
                    bank_src_o[b]  <= bank_sel[b];
                end
            end
        end
    end

    assign idle_o = ~(|buf_valid) & ~(|bank_we_o);

endmodule

// File: tb/tb_spatz_vrf_wb_arbiter.sv
module tb_spatz_vrf_wb_arbiter;

  localparam int NB = 4;
  localparam int NR = 3;
  localparam int AW = 8;
  localparam int DW = 64;
  localparam int BW = 8;
  localparam int T  = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NR-1:0]         req_valid;
  logic [NR-1:0]         req_ready;
  logic [NR-1:0][AW-1:0] req_addr;
  logic [NR-1:0][DW-1:0] req_data;
  logic [NR-1:0][BW-1:0] req_be;
  logic [NB-1:0]         bank_we;
  logic [NB-1:0][AW-1:0] bank_addr;
  logic [NB-1:0][DW-1:0] bank_data;
  logic [NB-1:0][BW-1:0] bank_be;
  logic [NB-1:0][1:0]    bank_src;
  logic                  idle;

  spatz_vrf_wb_arbiter dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_addr_i  (req_addr),
    .req_data_i  (req_data),
    .req_be_i    (req_be),
    .bank_we_o   (bank_we),
    .bank_addr_o (bank_addr),
    .bank_data_o (bank_data),
    .bank_be_o   (bank_be),
    .bank_src_o  (bank_src),
    .idle_o      (idle)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: per-requester queue of accepted writes {accept_cycle, addr, data, be}
  logic [111:0] exp_q [NR][$];

  always @(negedge clk) begin
    logic [111:0] e;
    int s;
    int lat;
    for (int b = 0; b < NB; b++) begin
      if (bank_we[b] === 1'b1) begin
        vectors++;
        s = int'(bank_src[b]);
        if (s >= NR || exp_q[s].size() == 0) begin
          miscompares++;
          $display("FAIL sb_spurious: bank %0d wrote src %0d, required no write", b, s);
        end else begin
          e = exp_q[s].pop_front();
          lat = cyc - int'(e[111:80]);
          if ({bank_addr[b], bank_data[b], bank_be[b]} !== e[79:0] || e[73:72] != 2'(b)
              || lat < 2 || lat > 2 * (T + 1) + 2) begin
            miscompares++;
            $display("FAIL sb_write: bank %0d src %0d got %h/%h/%h lat %0d, required %h/%h/%h on bank %0d lat 2..%0d",
                     b, s, bank_addr[b], bank_data[b], bank_be[b], lat,
                     e[79:72], e[71:8], e[7:0], e[73:72], 2 * (T + 1) + 2);
          end
        end
      end
    end
    if (rst) begin
      for (int r = 0; r < NR; r++) exp_q[r].delete();
    end else begin
      for (int r = 0; r < NR; r++)
        if (req_valid[r] === 1'b1 && req_ready[r] === 1'b1)
          exp_q[r].push_back({cyc, req_addr[r], req_data[r], req_be[r]});
    end
  end

  // driver helpers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    bit done;
    done = 0;
    req_valid = '0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (idle === 1'b1) done = 1;
    end
    #1;
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL %s_idle_timeout: idle %b, required 1 within 60 cycles", name, idle);
    end
    for (int r = 0; r < NR; r++) begin
      vectors++;
      if (exp_q[r].size() != 0) begin
        miscompares++;
        $display("FAIL %s_lost: requester %0d has %0d writes never seen, required 0", name, r, exp_q[r].size());
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int r = 0; r < NR; r++) begin
      req_valid[r] = 1'b1;
      req_addr[r]  = 8'($urandom);
      req_data[r]  = {$urandom, $urandom};
      req_be[r]    = 8'($urandom);
    end
    step();
    step();
    @(negedge clk);
    vectors++; if (req_ready !== 3'b111) begin miscompares++; $display("FAIL reset_ready: got %b required 111", req_ready); end
    vectors++; if (bank_we !== 4'b0000) begin miscompares++; $display("FAIL reset_we: got %b required 0000", bank_we); end
    vectors++; if (bank_addr !== '0 || bank_data !== '0 || bank_be !== '0 || bank_src !== '0) begin
      miscompares++; $display("FAIL reset_bank_fields: got %h %h %h %h required all zero", bank_addr, bank_data, bank_be, bank_src); end
    vectors++; if (idle !== 1'b1) begin miscompares++; $display("FAIL reset_idle: got %b required 1", idle); end
    step();
    rst = 1'b0;
    req_valid = '0;
    @(negedge clk);
    vectors++; if (idle !== 1'b1 || bank_we !== 4'b0000) begin
      miscompares++; $display("FAIL post_reset: idle %b we %b required 1 0000", idle, bank_we); end
  endtask

  task automatic test_single_write();
    for (int k = 0; k < 5; k++) begin
      step();
      req_valid = '0;
      if (k == 0) begin
        req_valid[0] = 1'b1;
        req_addr[0]  = 8'h01;
        req_data[0]  = 64'hA5;
        req_be[0]    = 8'hFF;
      end
      @(negedge clk);
      if (k == 0) begin
        vectors++; if (req_ready[0] !== 1'b1) begin miscompares++; $display("FAIL single_ready: got %b required 1", req_ready[0]); end
      end
      if (k == 1) begin
        vectors++; if (bank_we !== 4'b0000 || idle !== 1'b0) begin
          miscompares++; $display("FAIL single_c1: we %b idle %b required 0000 0", bank_we, idle); end
      end
      if (k == 2) begin
        vectors++; if (bank_we !== 4'b0010) begin miscompares++; $display("FAIL single_we: got %b required 0010", bank_we); end
        vectors++; if (bank_src[1] !== 2'd0 || bank_addr[1] !== 8'h01 || bank_data[1] !== 64'hA5 || bank_be[1] !== 8'hFF) begin
          miscompares++; $display("FAIL single_fields: got src %0d addr %h data %h be %h required 0 01 a5 ff",
                                  bank_src[1], bank_addr[1], bank_data[1], bank_be[1]); end
      end
      if (k == 3) begin
        vectors++; if (bank_we !== 4'b0000 || idle !== 1'b1) begin
          miscompares++; $display("FAIL single_c3: we %b idle %b required 0000 1", bank_we, idle); end
        vectors++; if (bank_addr[1] !== 8'h01 || bank_data[1] !== 64'hA5) begin
          miscompares++; $display("FAIL single_hold: got %h %h required 01 a5", bank_addr[1], bank_data[1]); end
      end
    end
    drain("single");
  endtask

  task automatic test_parallel();
    for (int k = 0; k < 12; k++) begin
      step();
      for (int r = 0; r < NR; r++) begin
        req_valid[r] = (k < 10);
        req_addr[r]  = {6'($urandom), 2'(r)};
        req_data[r]  = {$urandom, $urandom};
        req_be[r]    = 8'($urandom);
      end
      @(negedge clk);
      if (k < 10) begin
        vectors++; if (req_ready !== 3'b111) begin miscompares++; $display("FAIL parallel_ready k%0d: got %b required 111", k, req_ready); end
      end
      if (k >= 2) begin
        vectors++; if (bank_we !== 4'b0111) begin miscompares++; $display("FAIL parallel_we k%0d: got %b required 0111", k, bank_we); end
      end
    end
    drain("parallel");
  endtask

  task automatic test_conflict();
    int exp_g[21];
    logic [2:0] acc;
    logic [2:0] er;
    // grant order with all three buffered on one bank: VFU until the others
    // reach age 8 (9th waiting cycle), then VLSU, then VSLD, and repeat
    exp_g = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0};
    acc = '1;
    for (int k = 0; k <= 20; k++) begin
      step();
      for (int r = 0; r < NR; r++) begin
        req_valid[r] = (k <= 19);
        if (acc[r]) begin
          req_addr[r] = {6'($urandom), 2'b11};
          req_data[r] = {$urandom, $urandom};
          req_be[r]   = 8'($urandom);
        end
      end
      @(negedge clk);
      acc = req_ready & req_valid;
      er = (k == 0) ? 3'b111 : (3'b001 << exp_g[k]);
      vectors++; if (req_ready !== er) begin miscompares++; $display("FAIL conflict_ready k%0d: got %b required %b", k, req_ready, er); end
      if (k >= 2) begin
        vectors++; if (bank_we !== 4'b1000 || bank_src[3] !== 2'(exp_g[k-1])) begin
          miscompares++; $display("FAIL conflict_grant k%0d: we %b src %0d required 1000 %0d", k, bank_we, bank_src[3], exp_g[k-1]); end
      end
    end
    drain("conflict");
  endtask

  task automatic test_backpressure();
    logic [63:0] d2 [3];
    logic acc0;
    logic [2:0] er;
    int idx;
    for (int i = 0; i < 3; i++) d2[i] = {$urandom, $urandom};
    idx = 0;
    acc0 = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      step();
      req_valid = '0;
      if (k <= 19) begin
        req_valid[0] = 1'b1;
        if (acc0) begin
          req_addr[0] = {6'($urandom), 2'b10};
          req_data[0] = {$urandom, $urandom};
          req_be[0]   = 8'($urandom);
        end
        req_valid[2] = 1'b1;
        req_addr[2]  = 8'h0E;
        req_data[2]  = d2[idx];
        req_be[2]    = 8'hF0;
      end
      @(negedge clk);
      acc0 = req_ready[0] & req_valid[0];
      if (k <= 19) begin
        er = {(k % 9 == 0), 1'b1, (k == 0) || (k % 9 != 0)};
        vectors++; if (req_ready !== er) begin miscompares++; $display("FAIL bp_ready k%0d: got %b required %b", k, req_ready, er); end
      end
      if (k >= 2) begin
        vectors++; if (bank_we !== 4'b0100) begin miscompares++; $display("FAIL bp_we k%0d: got %b required 0100", k, bank_we); end
      end
      if (k == 10 || k == 19) begin
        vectors++; if (bank_src[2] !== 2'd2 || bank_data[2] !== d2[(k == 10) ? 0 : 1]) begin
          miscompares++; $display("FAIL bp_vsld k%0d: src %0d data %h required 2 %h", k, bank_src[2], bank_data[2], d2[(k == 10) ? 0 : 1]); end
      end
      if (k <= 19 && req_ready[2] === 1'b1) idx++;
    end
    drain("backpressure");
  endtask

  task automatic test_mid_reset();
    for (int k = 0; k <= 6; k++) begin
      step();
      rst = (k == 3);
      req_valid = '0;
      if (k <= 3) begin
        for (int r = 0; r < NR; r++) begin
          req_valid[r] = 1'b1;
          req_addr[r]  = {6'($urandom), 2'b00};
          req_data[r]  = {$urandom, $urandom};
          req_be[r]    = 8'($urandom);
        end
      end
      if (k == 4) begin
        req_valid[0] = 1'b1;
        req_addr[0]  = 8'h45;
        req_data[0]  = {$urandom, $urandom};
        req_be[0]    = 8'h00;
      end
      @(negedge clk);
      if (k == 3) begin
        vectors++; if (req_ready !== 3'b111) begin miscompares++; $display("FAIL mreset_ready: got %b required 111", req_ready); end
      end
      if (k == 4) begin
        vectors++; if (bank_we !== 4'b0000 || idle !== 1'b1) begin
          miscompares++; $display("FAIL mreset_after: we %b idle %b required 0000 1", bank_we, idle); end
        vectors++; if (bank_addr !== '0 || bank_data !== '0 || bank_be !== '0 || bank_src !== '0) begin
          miscompares++; $display("FAIL mreset_fields: got %h %h %h %h required all zero", bank_addr, bank_data, bank_be, bank_src); end
        vectors++; if (req_ready[0] !== 1'b1) begin miscompares++; $display("FAIL mreset_first_accept: got %b required 1", req_ready[0]); end
      end
      if (k == 5) begin
        vectors++; if (bank_we !== 4'b0000) begin miscompares++; $display("FAIL mreset_c5: got %b required 0000", bank_we); end
      end
      if (k == 6) begin
        vectors++; if (bank_we !== 4'b0010 || bank_addr[1] !== 8'h45 || bank_be[1] !== 8'h00) begin
          miscompares++; $display("FAIL mreset_be0: we %b addr %h be %h required 0010 45 00", bank_we, bank_addr[1], bank_be[1]); end
      end
    end
    drain("mid_reset");
  endtask

  task automatic test_random();
    logic [2:0] acc;
    acc = '1;
    req_valid = '0;
    for (int k = 0; k < 400; k++) begin
      step();
      for (int r = 0; r < NR; r++) begin
        if (!req_valid[r] || acc[r]) begin
          req_valid[r] = ($urandom_range(0, 3) != 0);
          req_addr[r]  = 8'($urandom);
          req_data[r]  = {$urandom, $urandom};
          req_be[r]    = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
        end
      end
      @(negedge clk);
      acc = req_ready & req_valid;
    end
    drain("random");
  endtask

  initial begin
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    req_be    = '0;
    test_reset();
    test_single_write();
    test_parallel();
    test_conflict();
    test_backpressure();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog");
  end

endmodule
